// File: rtl/id_pkg.sv
// Shared definitions for the MIPS decode stage.
//   - opcode / funct encodings of the decoded instruction subset
//   - ALU control codes driven onto IDEX_ALUctr
//   - idex_ctrl_t: control half of the ID/EX pipeline register
//     (the XLEN-wide data fields live in the top, since packages cannot be parameterised)
package id_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2a;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b100;

  typedef struct packed {
    logic [2:0]  alu_ctr;
    logic        alu_src;
    logic        mem_wr;
    logic        mem_to_reg;
    logic        reg_wr;
    logic        branch;
    logic        jump;
    logic [4:0]  rw;
    logic [25:0] target;
  } idex_ctrl_t;

endpackage

// File: rtl/id_regfile.sv
// Register file for the decode stage: two read ports, one write port.
//   clk_i, rst_ni        : clock, synchronous active-low clear of every register
//   we_i/waddr_i/wdata_i : write port, lands on the rising edge
//   raddr_*_i/rdata_*_o  : combinational read ports
// Register 0 reads as zero and ignores writes. A read of the address being written in the
// same cycle returns the write data (write-through).
module id_regfile #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_a_i,
  output logic [XLEN-1:0] rdata_a_o,
  input  logic [AW-1:0]   raddr_b_i,
  output logic [XLEN-1:0] rdata_b_o
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      regs_q <= '{default: '0};
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    if (raddr_a_i == '0) begin
      rdata_a_o = '0;
    end else if (we_i && (waddr_i == raddr_a_i)) begin
      rdata_a_o = wdata_i;
    end
  end

  always_comb begin
    rdata_b_o = regs_q[raddr_b_i];
    if (raddr_b_i == '0) begin
      rdata_b_o = '0;
    end else if (we_i && (waddr_i == raddr_b_i)) begin
      rdata_b_o = wdata_i;
    end
  end

endmodule

// File: rtl/id_decode_pipe.sv
// Pipelined MIPS decode stage: decode, register read with write-through, RAW hazard
// detection (stall / MEM forward) and the ID/EX pipeline register.
//   CLK, Reset (sync, active-low)
//   IF_Valid/IF_Inst/IF_Ready : instruction handshake from IF/ID
//   WB_Reg_Wr/WB_Rw/BusW      : writeback port into the register file
//   MEM_*                     : destination info of the instruction in MEM
//   EX_Ready, Flush           : downstream back-pressure, taken-branch discard
//   IDEX_*                    : registered ID/EX bundle
// Build option: define ID_FWD_EN to forward MEM_Result into the source operands when MEM
// holds a non-load writer; otherwise such a dependence stalls until writeback.
module id_decode_pipe
  import id_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            IF_Valid,
  input  logic [31:0]     IF_Inst,
  output logic            IF_Ready,
  input  logic            WB_Reg_Wr,
  input  logic [4:0]      WB_Rw,
  input  logic [XLEN-1:0] BusW,
  input  logic            MEM_RegWr,
  input  logic            MEM_MemtoReg,
  input  logic [4:0]      MEM_Rw,
  input  logic [XLEN-1:0] MEM_Result,
  input  logic            EX_Ready,
  input  logic            Flush,
  output logic            IDEX_Valid,
  output logic [XLEN-1:0] IDEX_BusA,
  output logic [XLEN-1:0] IDEX_BusB,
  output logic [XLEN-1:0] IDEX_Imm,
  output logic [2:0]      IDEX_ALUctr,
  output logic            IDEX_ALUSrc,
  output logic            IDEX_MemWr,
  output logic            IDEX_MemtoReg,
  output logic            IDEX_RegWr,
  output logic            IDEX_Branch,
  output logic            IDEX_Jump,
  output logic [4:0]      IDEX_Rw,
  output logic [25:0]     IDEX_Target
);

  localparam int unsigned AW = $clog2(NREG);

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;

  assign opcode = IF_Inst[31:26];
  assign rs     = IF_Inst[25:21];
  assign rt     = IF_Inst[20:16];
  assign rd     = IF_Inst[15:11];
  assign imm16  = IF_Inst[15:0];
  assign funct  = IF_Inst[5:0];

  idex_ctrl_t      dec_ctrl;
  logic            sign_ext, use_rs, use_rt;
  logic [XLEN-1:0] dec_imm;

  // Unrecognised encodings fall through with every write/branch control at 0 (NOP).
  always_comb begin
    dec_ctrl        = '0;
    dec_ctrl.target = IF_Inst[25:0];
    dec_ctrl.rw     = (opcode == OpRtype) ? rd : rt;
    sign_ext        = 1'b1;
    use_rs          = 1'b1;
    use_rt          = 1'b0;
    case (opcode)
      OpRtype: begin
        use_rt = 1'b1;
        case (funct)
          FnAdd:   begin dec_ctrl.reg_wr = 1'b1; dec_ctrl.alu_ctr = AluAdd; end
          FnSub:   begin dec_ctrl.reg_wr = 1'b1; dec_ctrl.alu_ctr = AluSub; end
          FnAnd:   begin dec_ctrl.reg_wr = 1'b1; dec_ctrl.alu_ctr = AluAnd; end
          FnOr:    begin dec_ctrl.reg_wr = 1'b1; dec_ctrl.alu_ctr = AluOr;  end
          FnSlt:   begin dec_ctrl.reg_wr = 1'b1; dec_ctrl.alu_ctr = AluSlt; end
          default: ;
        endcase
      end
      OpAddi: begin
        dec_ctrl.reg_wr  = 1'b1;
        dec_ctrl.alu_src = 1'b1;
      end
      OpOri: begin
        dec_ctrl.reg_wr  = 1'b1;
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.alu_ctr = AluOr;
        sign_ext         = 1'b0;
      end
      OpLw: begin
        dec_ctrl.reg_wr     = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
      end
      OpSw: begin
        dec_ctrl.mem_wr  = 1'b1;
        dec_ctrl.alu_src = 1'b1;
        use_rt           = 1'b1;
      end
      OpBeq: begin
        dec_ctrl.branch  = 1'b1;
        dec_ctrl.alu_ctr = AluSub;
        use_rt           = 1'b1;
      end
      OpJ: begin
        dec_ctrl.jump = 1'b1;
        use_rs        = 1'b0;
      end
      default: ;
    endcase
    dec_imm = sign_ext ? XLEN'($signed(imm16)) : XLEN'(imm16);
  end

  // ID/EX pipeline register.
  logic            valid_q;
  idex_ctrl_t      ctrl_q;
  logic [XLEN-1:0] bus_a_q, bus_b_q, imm_q;

  logic [AW-1:0]   rs_idx, rt_idx, ex_idx, mem_idx;
  logic [XLEN-1:0] rf_a, rf_b, src_a, src_b;

  assign rs_idx  = rs[AW-1:0];
  assign rt_idx  = rt[AW-1:0];
  assign ex_idx  = ctrl_q.rw[AW-1:0];
  assign mem_idx = MEM_Rw[AW-1:0];

  id_regfile #(
    .XLEN(XLEN),
    .NREG(NREG)
  ) u_regfile (
    .clk_i    (CLK),
    .rst_ni   (Reset),
    .we_i     (WB_Reg_Wr),
    .waddr_i  (WB_Rw[AW-1:0]),
    .wdata_i  (BusW),
    .raddr_a_i(rs_idx),
    .rdata_a_o(rf_a),
    .raddr_b_i(rt_idx),
    .rdata_b_o(rf_b)
  );

  logic chk_a, chk_b, ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic stall_a, stall_b, hazard, advance;

  always_comb begin
    chk_a     = use_rs && (rs_idx != '0);
    chk_b     = use_rt && (rt_idx != '0);
    ex_hit_a  = chk_a && valid_q && ctrl_q.reg_wr && (ex_idx == rs_idx);
    ex_hit_b  = chk_b && valid_q && ctrl_q.reg_wr && (ex_idx == rt_idx);
    mem_hit_a = chk_a && MEM_RegWr && (mem_idx == rs_idx);
    mem_hit_b = chk_b && MEM_RegWr && (mem_idx == rt_idx);
`ifdef ID_FWD_EN
    // Only a load in MEM has no value yet; ALU results are taken straight from MEM.
    stall_a = ex_hit_a || (mem_hit_a && MEM_MemtoReg);
    stall_b = ex_hit_b || (mem_hit_b && MEM_MemtoReg);
    src_a   = (mem_hit_a && !MEM_MemtoReg) ? MEM_Result : rf_a;
    src_b   = (mem_hit_b && !MEM_MemtoReg) ? MEM_Result : rf_b;
`else
    stall_a = ex_hit_a || mem_hit_a;
    stall_b = ex_hit_b || mem_hit_b;
    src_a   = rf_a;
    src_b   = rf_b;
`endif
    hazard  = stall_a || stall_b;
    advance = !valid_q || EX_Ready;
  end

`ifndef ID_FWD_EN
  logic unused_mem_result;
  assign unused_mem_result = ^MEM_Result;
`endif

  assign IF_Ready = Reset && advance && !(IF_Valid && hazard && !Flush);

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      bus_a_q <= '0;
      bus_b_q <= '0;
      imm_q   <= '0;
    end else if (Flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (advance) begin
      if (hazard) begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
      end else begin
        valid_q <= IF_Valid;
        ctrl_q  <= dec_ctrl;
        bus_a_q <= src_a;
        bus_b_q <= src_b;
        imm_q   <= dec_imm;
      end
    end
  end

  assign IDEX_Valid    = valid_q;
  assign IDEX_BusA     = bus_a_q;
  assign IDEX_BusB     = bus_b_q;
  assign IDEX_Imm      = imm_q;
  assign IDEX_ALUctr   = ctrl_q.alu_ctr;
  assign IDEX_ALUSrc   = ctrl_q.alu_src;
  assign IDEX_MemWr    = ctrl_q.mem_wr;
  assign IDEX_MemtoReg = ctrl_q.mem_to_reg;
  assign IDEX_RegWr    = ctrl_q.reg_wr;
  assign IDEX_Branch   = ctrl_q.branch;
  assign IDEX_Jump     = ctrl_q.jump;
  assign IDEX_Rw       = ctrl_q.rw;
  assign IDEX_Target   = ctrl_q.target;

endmodule

// File: tb/tb_id_decode_pipe.sv
module tb_id_decode_pipe;

  logic        CLK = 1'b0;
  logic        Reset, IF_Valid, IF_Ready;
  logic [31:0] IF_Inst;
  logic        WB_Reg_Wr;
  logic [4:0]  WB_Rw;
  logic [31:0] BusW;
  logic        MEM_RegWr, MEM_MemtoReg;
  logic [4:0]  MEM_Rw;
  logic [31:0] MEM_Result;
  logic        EX_Ready, Flush;
  logic        IDEX_Valid;
  logic [31:0] IDEX_BusA, IDEX_BusB, IDEX_Imm;
  logic [2:0]  IDEX_ALUctr;
  logic        IDEX_ALUSrc, IDEX_MemWr, IDEX_MemtoReg, IDEX_RegWr, IDEX_Branch, IDEX_Jump;
  logic [4:0]  IDEX_Rw;
  logic [25:0] IDEX_Target;

  id_decode_pipe #(.XLEN(32), .NREG(32)) dut (
    .CLK(CLK), .Reset(Reset), .IF_Valid(IF_Valid), .IF_Inst(IF_Inst), .IF_Ready(IF_Ready),
    .WB_Reg_Wr(WB_Reg_Wr), .WB_Rw(WB_Rw), .BusW(BusW),
    .MEM_RegWr(MEM_RegWr), .MEM_MemtoReg(MEM_MemtoReg), .MEM_Rw(MEM_Rw),
    .MEM_Result(MEM_Result), .EX_Ready(EX_Ready), .Flush(Flush),
    .IDEX_Valid(IDEX_Valid), .IDEX_BusA(IDEX_BusA), .IDEX_BusB(IDEX_BusB),
    .IDEX_Imm(IDEX_Imm), .IDEX_ALUctr(IDEX_ALUctr), .IDEX_ALUSrc(IDEX_ALUSrc),
    .IDEX_MemWr(IDEX_MemWr), .IDEX_MemtoReg(IDEX_MemtoReg), .IDEX_RegWr(IDEX_RegWr),
    .IDEX_Branch(IDEX_Branch), .IDEX_Jump(IDEX_Jump), .IDEX_Rw(IDEX_Rw),
    .IDEX_Target(IDEX_Target)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    IF_Valid  = 1'b0;
    MEM_RegWr = 1'b0;
    WB_Reg_Wr = 1'b0;
    tick();
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    IF_Valid  = 1'b0;
    WB_Reg_Wr = 1'b1;
    WB_Rw     = r;
    BusW      = d;
    tick();
    WB_Reg_Wr = 1'b0;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [2:0]  ctr;
    logic        src, mwr, m2r, rwr, br, jmp;
    logic [4:0]  rw;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    //                inst          imm           ctr    src   mwr   m2r   rwr   br    jmp   rw
    vecs[0]  = '{32'h20010005, 32'h00000005, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1};
    vecs[1]  = '{32'h2002FFFD, 32'hFFFFFFFD, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2};
    vecs[2]  = '{32'h34038001, 32'h00008001, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3};
    vecs[3]  = '{32'h8C04FFFC, 32'hFFFFFFFC, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4};
    vecs[4]  = '{32'hAC050008, 32'h00000008, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5};
    vecs[5]  = '{32'h1000FFFF, 32'hFFFFFFFF, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
    vecs[6]  = '{32'h08000456, 32'h00000456, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0};
    vecs[7]  = '{32'h00003820, 32'h00003820, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7};
    vecs[8]  = '{32'h00004022, 32'h00004022, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8};
    vecs[9]  = '{32'h00004824, 32'h00004824, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9};
    vecs[10] = '{32'h00005025, 32'h00005025, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd10};
    vecs[11] = '{32'h0000582A, 32'h0000582A, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd11};
    vecs[12] = '{32'hFC000000, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[13] = '{32'h0000603F, 32'h0000603F, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12};

    Reset = 1'b0; IF_Valid = 1'b0; IF_Inst = '0;
    WB_Reg_Wr = 1'b0; WB_Rw = '0; BusW = '0;
    MEM_RegWr = 1'b0; MEM_MemtoReg = 1'b0; MEM_Rw = '0; MEM_Result = '0;
    EX_Ready = 1'b1; Flush = 1'b0;

    // Reset state
    tick(); tick();
    chk("reset IDEX_Valid", IDEX_Valid, 0);
    chk("reset IDEX_RegWr", IDEX_RegWr, 0);
    chk("reset IDEX_BusA", IDEX_BusA, 0);
    chk("reset IF_Ready", IF_Ready, 0);
    Reset = 1'b1;
    tick();

    // Single-instruction decode table (register file all zero)
    for (int i = 0; i < 14; i++) begin
      IF_Valid = 1'b1;
      IF_Inst  = vecs[i].inst;
      settle();
      chk($sformatf("v%0d IF_Ready", i), IF_Ready, 1);
      tick();
      chk($sformatf("v%0d Valid", i), IDEX_Valid, 1);
      chk($sformatf("v%0d Imm", i), IDEX_Imm, vecs[i].imm);
      chk($sformatf("v%0d ALUctr", i), IDEX_ALUctr, vecs[i].ctr);
      chk($sformatf("v%0d ctl", i),
          {IDEX_ALUSrc, IDEX_MemWr, IDEX_MemtoReg, IDEX_RegWr, IDEX_Branch, IDEX_Jump},
          {vecs[i].src, vecs[i].mwr, vecs[i].m2r, vecs[i].rwr, vecs[i].br, vecs[i].jmp});
      chk($sformatf("v%0d Rw", i), IDEX_Rw, vecs[i].rw);
      chk($sformatf("v%0d BusA", i), IDEX_BusA, 0);
      idle();
    end
    IF_Valid = 1'b1; IF_Inst = 32'h08000456;
    tick();
    chk("j Target", IDEX_Target, 26'h0000456);
    idle();

    // addi $1,$0,5 then addi $2,$0,-3 back to back
    IF_Valid = 1'b1; IF_Inst = 32'h20010005;
    tick();
    IF_Inst = 32'h2002FFFD;
    settle();
    chk("addi pair IF_Ready", IF_Ready, 1);
    tick();
    chk("addi2 Valid", IDEX_Valid, 1);
    chk("addi2 Imm", IDEX_Imm, 32'hFFFFFFFD);
    chk("addi2 BusA", IDEX_BusA, 0);
    chk("addi2 ALUctr", IDEX_ALUctr, 3'b000);
    wb_write(5'd1, 32'h00000005);
    wb_write(5'd2, 32'hFFFFFFFD);
    IF_Valid = 1'b1; IF_Inst = 32'h00406820;  // add $13,$2,$0
    tick();
    chk("read $2", IDEX_BusA, 32'hFFFFFFFD);
    chk("read $0", IDEX_BusB, 0);
    idle();

    // Load-use: lw $3 then add $4,$3,$3
    IF_Valid = 1'b1; IF_Inst = 32'h8C030000;
    tick();
    IF_Inst = 32'h00632020;
    settle();
    chk("lu c1 IF_Ready", IF_Ready, 0);
    tick();
    chk("lu c1 Valid", IDEX_Valid, 0);
    MEM_RegWr = 1'b1; MEM_MemtoReg = 1'b1; MEM_Rw = 5'd3; MEM_Result = 32'h00000044;
    settle();
    chk("lu c2 IF_Ready", IF_Ready, 0);
    tick();
    chk("lu c2 Valid", IDEX_Valid, 0);
    MEM_RegWr = 1'b0; MEM_MemtoReg = 1'b0;
    WB_Reg_Wr = 1'b1; WB_Rw = 5'd3; BusW = 32'hCAFE0003;
    settle();
    chk("lu c3 IF_Ready", IF_Ready, 1);
    tick();
    WB_Reg_Wr = 1'b0;
    chk("lu add Valid", IDEX_Valid, 1);
    chk("lu add BusA", IDEX_BusA, 32'hCAFE0003);
    chk("lu add BusB", IDEX_BusB, 32'hCAFE0003);
    chk("lu add Rw", IDEX_Rw, 5'd4);
    idle();

    // ALU dependence: add $5,$1,$1 then sub $6,$5,$1
    IF_Valid = 1'b1; IF_Inst = 32'h00212820;
    tick();
    chk("alu add BusA", IDEX_BusA, 32'd5);
    IF_Inst = 32'h00A13022;
    settle();
    chk("alu c1 IF_Ready", IF_Ready, 0);
    tick();
    chk("alu c1 Valid", IDEX_Valid, 0);
    MEM_RegWr = 1'b1; MEM_MemtoReg = 1'b0; MEM_Rw = 5'd5; MEM_Result = 32'd10;
`ifdef ID_FWD_EN
    settle();
    chk("alu fwd IF_Ready", IF_Ready, 1);
    tick();
`else
    settle();
    chk("alu c2 IF_Ready", IF_Ready, 0);
    tick();
    chk("alu c2 Valid", IDEX_Valid, 0);
    MEM_RegWr = 1'b0;
    WB_Reg_Wr = 1'b1; WB_Rw = 5'd5; BusW = 32'd10;
    settle();
    chk("alu wb IF_Ready", IF_Ready, 1);
    tick();
`endif
    MEM_RegWr = 1'b0; WB_Reg_Wr = 1'b0;
    chk("sub Valid", IDEX_Valid, 1);
    chk("sub BusA", IDEX_BusA, 32'd10);
    chk("sub BusB", IDEX_BusB, 32'd5);
    chk("sub ALUctr", IDEX_ALUctr, 3'b001);

    // Back-pressure for 3 cycles with ori $7,$0,0x1234 waiting
    EX_Ready = 1'b0; IF_Inst = 32'h34071234;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("bp%0d IF_Ready", c), IF_Ready, 0);
      tick();
      chk($sformatf("bp%0d Valid", c), IDEX_Valid, 1);
      chk($sformatf("bp%0d Rw", c), IDEX_Rw, 5'd6);
      chk($sformatf("bp%0d BusA", c), IDEX_BusA, 32'd10);
      chk($sformatf("bp%0d ALUctr", c), IDEX_ALUctr, 3'b001);
    end
    EX_Ready = 1'b1;
    settle();
    chk("bp release IF_Ready", IF_Ready, 1);
    tick();
    chk("ori Rw", IDEX_Rw, 5'd7);
    chk("ori Imm", IDEX_Imm, 32'h00001234);

    // Flush wins over EX_Ready=0
    IF_Valid = 1'b0; EX_Ready = 1'b0; Flush = 1'b1;
    tick();
    chk("flush vs bp Valid", IDEX_Valid, 0);
    EX_Ready = 1'b1; Flush = 1'b0;
    idle();

    // Flush during load-use stall: lw $9 then add $10,$9,$0
    IF_Valid = 1'b1; IF_Inst = 32'h8C090000;
    tick();
    IF_Inst = 32'h01205020;
    settle();
    chk("fl stall IF_Ready", IF_Ready, 0);
    Flush = 1'b1;
    settle();
    chk("fl IF_Ready", IF_Ready, 1);
    tick();
    chk("fl Valid", IDEX_Valid, 0);
    IF_Valid = 1'b0; Flush = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("fl after%0d Valid", c), IDEX_Valid, 0);
    end

    // Register 0: write of 0xDEADBEEF ignored, including same-cycle read
    WB_Reg_Wr = 1'b1; WB_Rw = 5'd0; BusW = 32'hDEADBEEF;
    IF_Valid = 1'b1; IF_Inst = 32'h00005820;
    tick();
    WB_Reg_Wr = 1'b0;
    chk("r0 same-cycle BusA", IDEX_BusA, 0);
    chk("r0 same-cycle BusB", IDEX_BusB, 0);
    tick();
    chk("r0 later BusA", IDEX_BusA, 0);

    // Reset low mid-stall: lw $12 then add $13,$12,$0
    IF_Inst = 32'h8C0C0000;
    tick();
    IF_Inst = 32'h01806820; Reset = 1'b0;
    settle();
    chk("rst stall IF_Ready", IF_Ready, 0);
    tick();
    chk("rst Valid", IDEX_Valid, 0);
    chk("rst RegWr", IDEX_RegWr, 0);
    Reset = 1'b1; IF_Inst = 32'h00207020;  // add $14,$1,$0
    settle();
    chk("post rst IF_Ready", IF_Ready, 1);
    tick();
    chk("post rst Valid", IDEX_Valid, 1);
    chk("post rst $1 cleared", IDEX_BusA, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_decode_pipe.md
# id_decode_pipe

Parametrised decode stage for the pipelined MIPS core. It sits between the IF/ID register and the EX stage, and does four jobs:
- decodes the instruction;
- reads an internal register file that has write-through bypass;
- detects RAW hazards, stalling or forwarding as needed;
- owns the ID/EX pipeline register, with a valid/ready handshake and flush.

It replaces the purely combinational decode and register-read path.

## Interface
- XLEN, 32: datapath width (≥16).
- NREG, 32: architectural registers, a power of two in 8..32. The register index is the low $clog2(NREG) bits of each 5-bit field.
- CLK  in  1  sole clock, rising edge.
- Reset  in  1  synchronous, active-low.
- IF_Valid  in  1  IF/ID holds an instruction.
- IF_Inst  in  32  instruction.
- IF_Ready  out  1  instruction consumed this cycle.
- WB_Reg_Wr  in  1  writeback enable.
- WB_Rw  in  5  writeback register.
- BusW  in  XLEN  writeback data.
- MEM_RegWr, MEM_MemtoReg  in  1 each  instruction in MEM writes a register / is a load.
- MEM_Rw  in  5  its destination.
- MEM_Result  in  XLEN  its ALU result.
- EX_Ready  in  1  EX accepts the ID/EX contents.
- Flush  in  1  taken branch/jump: discard ID and ID/EX.
- IDEX_Valid  out  1  ID/EX holds a real instruction.
- IDEX_BusA, IDEX_BusB, IDEX_Imm  out  XLEN each.
- IDEX_ALUctr  out  3.
- IDEX_ALUSrc, IDEX_MemWr, IDEX_MemtoReg, IDEX_RegWr, IDEX_Branch, IDEX_Jump  out  1 each.
- IDEX_Rw  out  5.
- IDEX_Target  out  26.

## Operation
- Decoded instructions:
  - R-type: add, sub, and, or, slt.
  - addi, ori, lw, sw, beq, j.
  - Any other encoding becomes a NOP: valid, but all write/branch controls are 0.
- IDEX_ALUctr encoding: add 000, sub 001, and 010, or 011, slt 100.
- Immediate extension: sign-extend for addi/lw/sw/beq, zero-extend for ori.
- Destination register: rd for R-type, rt otherwise.
- Source usage: rs is used by everything except j; rt is used by R-type, sw and beq. Unused sources and register 0 never raise a hazard.
- Register file:
  - Register 0 reads 0 and ignores writes.
  - A write with WB_Reg_Wr=1 and WB_Rw≠0 lands on the rising edge.
  - A same-cycle read of WB_Rw returns BusW (write-through).
- Hazard, per used source s≠0:
  - ID/EX valid with IDEX_RegWr and IDEX_Rw==s: stall.
  - MEM_RegWr, MEM_Rw==s and MEM_MemtoReg: stall.
  - MEM_RegWr, MEM_Rw==s and not MEM_MemtoReg: forward MEM_Result (ID_FWD_EN only; otherwise stall).
  - WB match: handled by the register-file bypass.
- Precedence for a source value: MEM forward > WB bypass > array read.
- advance = ~IDEX_Valid | EX_Ready.
- IF_Ready = Reset & advance & ~(IF_Valid & hazard & ~Flush).
- ID/EX update on each rising edge, highest priority first:
  - Reset low: all outputs 0, all registers 0.
  - Flush: IDEX_Valid←0; the ID instruction is dropped (IF_Ready=1).
  - ~advance: hold.
  - hazard: insert a bubble (IDEX_Valid←0, all controls 0).
  - otherwise: load the decode, with IDEX_Valid←IF_Valid.

## Timing
- Decode latency is one cycle: IF_Inst accepted on edge k appears on IDEX_* after edge k.
- Load-use stalls:
  - Load in ID/EX with a dependent instruction in ID: 2 bubbles.
  - Load in MEM with a dependent instruction in ID: 1 bubble.
- ALU-result dependence:
  - With ID_FWD_EN: 1 bubble.
  - Without ID_FWD_EN: 2 bubbles.
- A writeback landing in the same cycle as the dependent read: 0 bubbles.
- Flush arriving in the same cycle as a stall or as EX_Ready=0: flush wins.
- Reset low mid-stall: clears everything on that edge, and IF_Ready=0 during that cycle.
- Back-pressure: with EX_Ready=0 and IDEX_Valid=1, every IDEX_* output is stable and IF_Ready=0.

## Configuration
- ID_FWD_EN:
  - Defined: MEM_Result is forwarded into source operands when MEM holds a non-load writer.
  - Undefined: the forward mux is absent and any MEM-stage match stalls until writeback. Results stay architecturally identical; only cycle counts differ.

## Structure
- Package id_pkg holds:
  - opcode and funct localparams;
  - ALUctr codes;
  - a packed struct for the ID/EX bundle.
- Sub-module id_regfile:
  - parameters XLEN and NREG;
  - two read ports and one write port;
  - write-through bypass and register-0 handling.

## Test plan
- Reset, then a pattern of addi-based register writes: addi $1,$0,5 followed by addi $2,$0,-3 → IDEX_Imm=0xFFFFFFFD, IDEX_BusA=0, IDEX_ALUctr=000, and after WB, a read of $2 returns 0xFFFFFFFD.
- lw $3 immediately followed by add $4,$3,$3 → two cycles with IF_Ready=0 and IDEX_Valid=0, then IDEX_BusA=IDEX_BusB=BusW of the load.
- add $5 immediately followed by sub $6,$5,$1:
  - with ID_FWD_EN: one bubble, then IDEX_BusA=MEM_Result;
  - without it: two bubbles, then the value arrives via the WB bypass.
- EX_Ready held 0 for 3 cycles with IDEX_Valid=1 → IDEX_* unchanged and IF_Ready=0; on release the next instruction loads on the following edge.
- Flush asserted during a load-use stall → IDEX_Valid=0, IF_Ready=1, and the stalled instruction never appears on IDEX.
- Write $0 with BusW=0xDEADBEEF, then read $0 → 0. Also: an unknown opcode produces IDEX_Valid=1 with IDEX_RegWr=IDEX_MemWr=IDEX_Branch=IDEX_Jump=0.
